// File: rtl/obi_data_responder.sv
// obi_data_responder: slave end of the core data port (req/gnt/rvalid) backed by a
// word-addressed scratchpad with byte-enable writes.
// Latency: grant after wcnt >= W wait cycles (W = stall_en_i ? GNT_WAIT : 0);
//          rvalid exactly RESP_LAT cycles after the grant edge.
// Backpressure: grant withheld while OUTSTANDING responses are pending, unless one pops this cycle.
// Ports:
//   clk_i, rst_i                     clock, async active-high reset
//   data_req_i/addr/we/be/wdata      request channel from the core
//   data_gnt_o                       grant (combinational)
//   data_rvalid_o, data_rdata_o      in-order response channel (rdata 0 for writes)
//   stall_en_i                       enables GNT_WAIT wait states
//   err_cnt_o                        saturating count of out-of-window accesses
//   busy_o                           any transaction outstanding
module obi_data_responder #(
  parameter int          ADDR_WIDTH    = 10,
  parameter logic [31:0] BASE_ADDR     = 32'h0001_0000,
  parameter int          GNT_WAIT      = 2,
  parameter int          RESP_LAT      = 1,
  parameter int          OUTSTANDING   = 2,
  parameter logic [31:0] DEFAULT_RDATA = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  input  logic        stall_en_i,
  output logic [7:0]  err_cnt_o,
  output logic        busy_o
);

  localparam int CW    = $clog2(OUTSTANDING + 1);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Scratchpad (not reset)
  logic [31:0] mem [DEPTH];

  logic [3:0]  wcnt_q, wcnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0] q_rdata_q [OUTSTANDING];
  logic [31:0] q_rdata_d [OUTSTANDING];
  logic [2:0]  q_age_q   [OUTSTANDING];
  logic [2:0]  q_age_d   [OUTSTANDING];

  logic [3:0]            wait_lim;
  logic                  in_win;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  pop;
  logic                  room;
  logic                  gnt;
  logic [31:0]           push_rdata;
  logic [CW-1:0]         push_idx;

  // Byte offset is irrelevant for word accesses.
  logic unused_byte_offset;
  assign unused_byte_offset = ^data_addr_i[1:0];

  assign wait_lim = stall_en_i ? 4'(GNT_WAIT) : 4'd0;
  assign in_win   = (data_addr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
  assign word_idx = data_addr_i[ADDR_WIDTH+1:2];

  // Head entry is answered in the cycle its age reaches RESP_LAT-1; entries are
  // pushed with age 0 at the grant edge, so rvalid lands RESP_LAT cycles later.
  assign pop  = (count_q != '0) && (q_age_q[0] == 3'(RESP_LAT - 1));
  assign room = (count_q < CW'(OUTSTANDING)) || pop;
  // Grant is forced low while reset is held so nothing is accepted or written.
  assign gnt  = !rst_i && data_req_i && (wcnt_q >= wait_lim) && room;

  assign push_rdata = data_we_i ? 32'h0 : (in_win ? mem[word_idx] : DEFAULT_RDATA);
  // A popping entry frees its slot in the same cycle, so the new entry lands one lower.
  assign push_idx   = pop ? (count_q - CW'(1)) : count_q;

  always_comb begin
    wcnt_d    = wcnt_q;
    err_cnt_d = err_cnt_q;
    count_d   = count_q;
    q_rdata_d = q_rdata_q;
    q_age_d   = q_age_q;

    // Saturate so a long room stall cannot wrap the counter back below the wait limit.
    if (!data_req_i || gnt) begin
      wcnt_d = 4'd0;
    end else if (wcnt_q != 4'hF) begin
      wcnt_d = wcnt_q + 4'd1;
    end

    if (gnt && !in_win && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end

    if (gnt && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!gnt && pop) begin
      count_d = count_q - CW'(1);
    end

    // Age every entry; on a pop the queue shifts one slot towards the head.
    if (pop) begin
      for (int i = 0; i < OUTSTANDING - 1; i++) begin
        q_rdata_d[i] = q_rdata_q[i+1];
        q_age_d[i]   = q_age_q[i+1] + 3'd1;
      end
      q_rdata_d[OUTSTANDING-1] = 32'h0;
      q_age_d[OUTSTANDING-1]   = 3'd0;
    end else begin
      for (int i = 0; i < OUTSTANDING; i++) begin
        q_age_d[i] = q_age_q[i] + 3'd1;
      end
    end

    if (gnt) begin
      for (int i = 0; i < OUTSTANDING; i++) begin
        if (push_idx == CW'(i)) begin
          q_rdata_d[i] = push_rdata;
          q_age_d[i]   = 3'd0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wcnt_q    <= 4'd0;
      err_cnt_q <= 8'd0;
      count_q   <= '0;
      for (int i = 0; i < OUTSTANDING; i++) begin
        q_rdata_q[i] <= 32'h0;
        q_age_q[i]   <= 3'd0;
      end
    end else begin
      wcnt_q    <= wcnt_d;
      err_cnt_q <= err_cnt_d;
      count_q   <= count_d;
      q_rdata_q <= q_rdata_d;
      q_age_q   <= q_age_d;
    end
  end

  // Write executes at the grant edge; a read granted next cycle sees the new word.
  always_ff @(posedge clk_i) begin
    if (gnt && data_we_i && in_win) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) begin
          mem[word_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Response outputs decode only registered queue state.
  assign data_gnt_o    = gnt;
  assign data_rvalid_o = pop;
  assign data_rdata_o  = pop ? q_rdata_q[0] : 32'h0;
  assign err_cnt_o     = err_cnt_q;
  assign busy_o        = (count_q != '0);

endmodule

// File: tb/tb_obi_data_responder.sv
module tb_obi_data_responder;

  logic clk;
  logic rst_a, rst_b;

  // Instance A: default parameters (GNT_WAIT=2, RESP_LAT=1, OUTSTANDING=2)
  logic        a_req, a_we, a_stall;
  logic [31:0] a_addr, a_wdata;
  logic [3:0]  a_be;
  logic        a_gnt, a_rvalid, a_busy;
  logic [31:0] a_rdata;
  logic [7:0]  a_err;

  // Instance B: OUTSTANDING=1, RESP_LAT=3
  logic        b_req, b_we, b_stall;
  logic [31:0] b_addr, b_wdata;
  logic [3:0]  b_be;
  logic        b_gnt, b_rvalid, b_busy;
  logic [31:0] b_rdata;
  logic [7:0]  b_err;

  int checks = 0;
  int errors = 0;

  obi_data_responder #(
    .ADDR_WIDTH(10), .BASE_ADDR(32'h0001_0000), .GNT_WAIT(2),
    .RESP_LAT(1), .OUTSTANDING(2), .DEFAULT_RDATA(32'hDEAD_BEEF)
  ) u_dut (
    .clk_i(clk), .rst_i(rst_a),
    .data_req_i(a_req), .data_addr_i(a_addr), .data_we_i(a_we),
    .data_be_i(a_be), .data_wdata_i(a_wdata),
    .data_gnt_o(a_gnt), .data_rvalid_o(a_rvalid), .data_rdata_o(a_rdata),
    .stall_en_i(a_stall), .err_cnt_o(a_err), .busy_o(a_busy)
  );

  obi_data_responder #(
    .ADDR_WIDTH(10), .BASE_ADDR(32'h0001_0000), .GNT_WAIT(2),
    .RESP_LAT(3), .OUTSTANDING(1), .DEFAULT_RDATA(32'hDEAD_BEEF)
  ) u_bp (
    .clk_i(clk), .rst_i(rst_b),
    .data_req_i(b_req), .data_addr_i(b_addr), .data_we_i(b_we),
    .data_be_i(b_be), .data_wdata_i(b_wdata),
    .data_gnt_o(b_gnt), .data_rvalid_o(b_rvalid), .data_rdata_o(b_rdata),
    .stall_en_i(b_stall), .err_cnt_o(b_err), .busy_o(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        busy;
    logic [7:0]  err;
  } vec_t;

  function automatic vec_t mk(logic req, logic we, logic [31:0] addr, logic [3:0] be,
                              logic [31:0] wd, logic gnt, logic rv, logic [31:0] rd,
                              logic busy, logic [7:0] err);
    vec_t v;
    v.req = req; v.we = we; v.addr = addr; v.be = be; v.wdata = wd;
    v.gnt = gnt; v.rvalid = rv; v.rdata = rd; v.busy = busy; v.err = err;
    return v;
  endfunction

  // Hold a read request on instance A until granted; ncyc = req cycle of the grant (0 on timeout).
  task automatic a_hold_req(input logic [31:0] addr, output int ncyc,
                            output logic rv1, output logic [31:0] rd1);
    ncyc = 0; rv1 = 1'b0; rd1 = 32'h0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      a_req = 1'b1; a_we = 1'b0; a_addr = addr; a_be = 4'h0;
      #2;
      if (c == 1) begin rv1 = a_rvalid; rd1 = a_rdata; end
      if (a_gnt) begin ncyc = c; break; end
    end
  endtask

  // One full transaction on instance B; lat = cycles from grant cycle to rvalid (0 on timeout).
  task automatic b_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd);
    logic granted;
    granted = 1'b0; lat = 0; rd = 32'h0;
    for (int c = 0; c < 10 && !granted; c++) begin
      @(posedge clk); #1;
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; b_be = 4'hF;
      #2;
      granted = b_gnt;
    end
    if (granted) begin
      for (int c = 1; c <= 10; c++) begin
        @(posedge clk); #1;
        b_req = 1'b0;
        #2;
        if (b_rvalid) begin lat = c; rd = b_rdata; break; end
      end
    end
    @(posedge clk); #1; b_req = 1'b0;
  endtask

  vec_t vecs[26];
  int          n;
  logic        rv1;
  logic [31:0] rd1;
  int          lat;
  logic [31:0] rd;
  int          gcnt, rcnt;
  int          grant_cyc[4];
  int          rv_cyc[4];
  logic [31:0] rv_dat[4];
  int          gi, ri, busy_bad;

  initial begin
    vecs[0]  = mk(1'b0,1'b0,32'h0,          4'h0,32'h0,          1'b0,1'b0,32'h0,          1'b0,8'd0);
    vecs[1]  = mk(1'b1,1'b1,32'h0001_0010,4'hF,32'hA5A5_1234, 1'b1,1'b0,32'h0,          1'b0,8'd0);
    vecs[2]  = mk(1'b1,1'b0,32'h0001_0010,4'h0,32'h0,          1'b1,1'b1,32'h0,          1'b1,8'd0);
    vecs[3]  = mk(1'b0,1'b0,32'h0,          4'h0,32'h0,          1'b0,1'b1,32'hA5A5_1234, 1'b1,8'd0);
    vecs[4]  = mk(1'b1,1'b1,32'h0001_0020,4'hF,32'h1111_1111, 1'b1,1'b0,32'h0,          1'b0,8'd0);
    vecs[5]  = mk(1'b1,1'b1,32'h0001_0020,4'h5,32'hFFFF_FFFF, 1'b1,1'b1,32'h0,          1'b1,8'd0);
    vecs[6]  = mk(1'b1,1'b0,32'h0001_0020,4'h0,32'h0,          1'b1,1'b1,32'h0,          1'b1,8'd0);
    vecs[7]  = mk(1'b0,1'b0,32'h0,          4'h0,32'h0,          1'b0,1'b1,32'h11FF_11FF, 1'b1,8'd0);
    vecs[8]  = mk(1'b0,1'b0,32'h0,          4'h0,32'h0,          1'b0,1'b0,32'h0,          1'b0,8'd0);
    vecs[9]  = mk(1'b1,1'b0,32'h0002_0000,4'h0,32'h0,          1'b1,1'b0,32'h0,          1'b0,8'd0);
    vecs[10] = mk(1'b0,1'b0,32'h0,          4'h0,32'h0,          1'b0,1'b1,32'hDEAD_BEEF, 1'b1,8'd1);
    vecs[11] = mk(1'b1,1'b1,32'h0001_0004,4'hF,32'hCAFE_0001, 1'b1,1'b0,32'h0,          1'b0,8'd1);
    vecs[12] = mk(1'b1,1'b1,32'h0002_0004,4'hF,32'h1234_5678, 1'b1,1'b1,32'h0,          1'b1,8'd1);
    vecs[13] = mk(1'b1,1'b0,32'h0001_0004,4'h0,32'h0,          1'b1,1'b1,32'h0,          1'b1,8'd2);
    vecs[14] = mk(1'b0,1'b0,32'h0,          4'h0,32'h0,          1'b0,1'b1,32'hCAFE_0001, 1'b1,8'd2);
    vecs[15] = mk(1'b1,1'b0,32'h0001_0013,4'h0,32'h0,          1'b1,1'b0,32'h0,          1'b0,8'd2);
    vecs[16] = mk(1'b1,1'b0,32'h0001_0020,4'h0,32'h0,          1'b1,1'b1,32'hA5A5_1234, 1'b1,8'd2);
    vecs[17] = mk(1'b0,1'b0,32'h0,          4'h0,32'h0,          1'b0,1'b1,32'h11FF_11FF, 1'b1,8'd2);
    vecs[18] = mk(1'b0,1'b0,32'h0,          4'h0,32'h0,          1'b0,1'b0,32'h0,          1'b0,8'd2);
    vecs[19] = mk(1'b1,1'b0,32'h0000_FFFC,4'h0,32'h0,          1'b1,1'b0,32'h0,          1'b0,8'd2);
    vecs[20] = mk(1'b0,1'b0,32'h0,          4'h0,32'h0,          1'b0,1'b1,32'hDEAD_BEEF, 1'b1,8'd3);
    vecs[21] = mk(1'b1,1'b1,32'h0001_0FFC,4'hF,32'h600D_F00D, 1'b1,1'b0,32'h0,          1'b0,8'd3);
    vecs[22] = mk(1'b1,1'b0,32'h0001_0FFC,4'h0,32'h0,          1'b1,1'b1,32'h0,          1'b1,8'd3);
    vecs[23] = mk(1'b1,1'b0,32'h0001_1000,4'h0,32'h0,          1'b1,1'b1,32'h600D_F00D, 1'b1,8'd3);
    vecs[24] = mk(1'b0,1'b0,32'h0,          4'h0,32'h0,          1'b0,1'b1,32'hDEAD_BEEF, 1'b1,8'd4);
    vecs[25] = mk(1'b0,1'b0,32'h0,          4'h0,32'h0,          1'b0,1'b0,32'h0,          1'b0,8'd4);

    a_req = 1'b0; a_we = 1'b0; a_addr = 32'h0; a_be = 4'h0; a_wdata = 32'h0; a_stall = 1'b0;
    b_req = 1'b0; b_we = 1'b0; b_addr = 32'h0; b_be = 4'h0; b_wdata = 32'h0; b_stall = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #3;
    chk("rst_gnt",    {31'h0, a_gnt},    32'h0);
    chk("rst_rvalid", {31'h0, a_rvalid}, 32'h0);
    chk("rst_rdata",  a_rdata,           32'h0);
    chk("rst_err",    {24'h0, a_err},    32'h0);
    chk("rst_busy",   {31'h0, a_busy},   32'h0);
    chk("rst_b_busy", {31'h0, b_busy},   32'h0);
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;

    // Table-driven single-cycle vectors, stall disabled
    for (int k = 0; k < 26; k++) begin
      @(posedge clk); #1;
      a_req = vecs[k].req; a_we = vecs[k].we; a_addr = vecs[k].addr;
      a_be = vecs[k].be; a_wdata = vecs[k].wdata;
      #2;
      chk($sformatf("vec%0d_gnt", k),    {31'h0, a_gnt},    {31'h0, vecs[k].gnt});
      chk($sformatf("vec%0d_rvalid", k), {31'h0, a_rvalid}, {31'h0, vecs[k].rvalid});
      if (vecs[k].rvalid)
        chk($sformatf("vec%0d_rdata", k), a_rdata, vecs[k].rdata);
      chk($sformatf("vec%0d_busy", k),   {31'h0, a_busy},   {31'h0, vecs[k].busy});
      chk($sformatf("vec%0d_err", k),    {24'h0, a_err},    {24'h0, vecs[k].err});
    end

    // Grant wait states: grant in the 3rd held-request cycle
    a_stall = 1'b1;
    a_hold_req(32'h0001_0010, n, rv1, rd1);
    chk("stall_first_gnt_cycle", n, 3);
    chk("stall_first_no_rvalid", {31'h0, rv1}, 32'h0);
    // Back-to-back request: wait counter must have cleared on the grant
    a_hold_req(32'h0001_0020, n, rv1, rd1);
    chk("stall_second_gnt_cycle", n, 3);
    chk("stall_rvalid_after_gnt", {31'h0, rv1}, 32'h1);
    chk("stall_rdata_after_gnt", rd1, 32'hA5A5_1234);
    @(posedge clk); #1; a_req = 1'b0; #2;
    chk("stall_second_rvalid", {31'h0, a_rvalid}, 32'h1);
    chk("stall_second_rdata", a_rdata, 32'h11FF_11FF);
    // Withdrawn request clears the wait counter
    @(posedge clk); #1; a_req = 1'b1; a_addr = 32'h0001_0004; #2;
    chk("withdraw_no_gnt", {31'h0, a_gnt}, 32'h0);
    @(posedge clk); #1; a_req = 1'b0; #2;
    a_hold_req(32'h0001_0004, n, rv1, rd1);
    chk("withdraw_gnt_cycle", n, 3);
    @(posedge clk); #1; a_req = 1'b0; #2;
    chk("withdraw_rdata", a_rdata, 32'hCAFE_0001);
    a_stall = 1'b0;

    // Error counter saturation: 300 back-to-back out-of-window reads
    gcnt = 0; rcnt = 0;
    for (int c = 0; c < 302; c++) begin
      @(posedge clk); #1;
      a_req = (c < 300); a_we = 1'b0; a_addr = 32'h0002_0000;
      #2;
      if (a_gnt) gcnt++;
      if (a_rvalid && a_rdata == 32'hDEAD_BEEF) rcnt++;
    end
    chk("oow_grants", gcnt, 300);
    chk("oow_default_rdata", rcnt, 300);
    chk("err_saturated", {24'h0, a_err}, 32'd255);

    // Instance B: preload four words, each answered 3 cycles after its grant
    for (int i = 0; i < 4; i++) begin
      b_txn(1'b1, 32'h0001_0000 + 32'(4 * i), 32'h0B0B_0000 + 32'(i), lat, rd);
      chk($sformatf("bp_wr%0d_lat", i), lat, 3);
      chk($sformatf("bp_wr%0d_rdata", i), rd, 32'h0);
    end

    // Back-pressure: four back-to-back reads with OUTSTANDING=1, RESP_LAT=3
    gi = 0; ri = 0; busy_bad = 0;
    for (int i = 0; i < 4; i++) begin grant_cyc[i] = -1; rv_cyc[i] = -1; rv_dat[i] = 32'h0; end
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      b_req = (gi < 4); b_we = 1'b0; b_addr = 32'h0001_0000 + 32'(4 * gi);
      #2;
      if (b_gnt && gi < 4) begin grant_cyc[gi] = c; gi++; end
      if (b_rvalid && ri < 4) begin rv_cyc[ri] = c; rv_dat[ri] = b_rdata; ri++; end
      if (c >= 1 && c <= 12 && !b_busy) busy_bad++;
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_gnt%0d_cycle", i), grant_cyc[i], 3 * i);
      chk($sformatf("bp_rv%0d_cycle", i), rv_cyc[i], 3 * i + 3);
      chk($sformatf("bp_rv%0d_rdata", i), rv_dat[i], 32'h0B0B_0000 + 32'(i));
    end
    chk("bp_busy_throughout", busy_bad, 0);

    // Reset mid-flight: the pending read must never be answered
    @(posedge clk); #1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'h0001_0000;
    #2;
    chk("midrst_gnt", {31'h0, b_gnt}, 32'h1);
    @(posedge clk); #1;
    b_req = 1'b0; rst_b = 1'b1;
    #2;
    chk("midrst_busy_in_reset", {31'h0, b_busy}, 32'h0);
    @(posedge clk); #1;
    rst_b = 1'b0;
    rcnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #3;
      if (b_rvalid) rcnt++;
    end
    chk("midrst_no_rvalid", rcnt, 0);
    chk("midrst_busy_after", {31'h0, b_busy}, 32'h0);
    b_txn(1'b0, 32'h0001_0004, 32'h0, lat, rd);
    chk("midrst_next_lat", lat, 3);
    chk("midrst_next_rdata", rd, 32'h0B0B_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
